dmd_video_gen: RTL and testbench

//  Parametrised dot-matrix-display (DMD) video generator: raster timing, dot grid with border, BPP-bit grey levels.

---
 rtl/dmd_wr_if.sv | 16 +
 rtl/dmd_video_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_dmd_video_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmd_wr_if.sv
// Pixel write stream into the DMD frame store.
//   wr_valid : beat valid (master -> slave)
//   wr_ready : beat accepted when wr_valid & wr_ready (slave -> master)
//   wr_data  : BPP-bit dot level, raster order, column fastest
//   wr_sof   : beat is dot (0,0) of a new frame
interface dmd_wr_if #(
  parameter int unsigned BPP = 4
);
  logic           wr_valid;
  logic           wr_ready;
  logic [BPP-1:0] wr_data;
  logic           wr_sof;

  modport master (output wr_valid, output wr_data, output wr_sof, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, input  wr_sof, output wr_ready);
endinterface

// File: rtl/dmd_video_gen.sv
// Dot-matrix-display video generator with a double-buffered frame store.
// A pixel stream fills the back bank; the banks swap at the start of vsync.
//   clk, rst_n            : pixel clock, async active-low reset
//   wr (slave)            : pixel write stream (valid/ready/data/sof)
//   tint[2:0]             : {R,G,B} channel enables
//   frame_done            : one-cycle pulse when the banks swap
//   DrawArea/hSync/vSync  : active video and active-high syncs
//   red/green/blue        : 8-bit colour
// Every video output is three clocks behind the raster counters.
module dmd_video_gen #(
  parameter int unsigned H_DRAW  = 1280,
  parameter int unsigned H_PORCH = 32,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_FRAME = 1440,
  parameter int unsigned V_DRAW  = 390,
  parameter int unsigned V_PORCH = 1,
  parameter int unsigned V_SYNC  = 24,
  parameter int unsigned V_FRAME = 442,
  parameter int unsigned DOT_W   = 10,
  parameter int unsigned DOT_H   = 10,
  parameter int unsigned BORDER  = 1,
  parameter int unsigned COLS    = 128,
  parameter int unsigned ROWS    = 32,
  parameter int unsigned BPP     = 4,
  parameter int unsigned BASE    = 50,
  parameter int unsigned STEP    = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  dmd_wr_if.slave     wr,
  input  logic [2:0]  tint,
  output logic        frame_done,
  output logic        DrawArea,
  output logic        hSync,
  output logic        vSync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int unsigned NPIX     = COLS * ROWS;
  localparam int unsigned AW       = $clog2(NPIX);
  localparam int unsigned MW       = $clog2(2 * NPIX);
  localparam int unsigned HW       = $clog2(H_FRAME + 1);
  localparam int unsigned VW       = $clog2(V_FRAME + 1);
  localparam int unsigned SXW      = $clog2(DOT_W + 1);
  localparam int unsigned SYW      = $clog2(DOT_H + 1);
  localparam int unsigned CW       = 10;
  localparam int unsigned FW       = 7;  // {draw, hs, vs, lit, tint[2:0]}
  localparam int unsigned HS_START = H_DRAW + H_PORCH;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DRAW + V_PORCH;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Stage 0: raster and dot counters
  logic [HW-1:0]  hcnt_q, hcnt_d, col_q, col_d;
  logic [VW-1:0]  vcnt_q, vcnt_d, row_q, row_d;
  logic [SXW-1:0] sx_q, sx_d;
  logic [SYW-1:0] sy_q, sy_d;

  // Stage 1 / 2 pipeline
  logic [FW-1:0]  s1_flags_q, s1_flags_d, s2_flags_q, s2_flags_d;
  logic [MW-1:0]  s1_raddr_q, s1_raddr_d;
  logic [BPP-1:0] rd_level_q;

  // Write side and bank control
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic           swap_pend_q, swap_pend_d;
  logic           front_q, front_d;
  logic           wr_ready_q, wr_ready_d;
  logic           frame_done_d;

  // Stage 3 output registers
  logic           draw_area_d, hsync_d, vsync_d;
  logic [7:0]     red_d, green_d, blue_d;

  logic [BPP-1:0] mem [2*NPIX];
  logic           wr_fire;
  logic [MW-1:0]  wr_maddr;

  // Raster counters; dot sub-counters restart with every line/frame wrap
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    col_d  = col_q;
    row_d  = row_q;
    if (hcnt_q == HW'(H_FRAME - 1)) begin
      hcnt_d = '0;
      sx_d   = '0;
      col_d  = '0;
      if (vcnt_q == VW'(V_FRAME - 1)) begin
        vcnt_d = '0;
        sy_d   = '0;
        row_d  = '0;
      end else begin
        vcnt_d = vcnt_q + VW'(1);
        if (sy_q == SYW'(DOT_H - 1)) begin
          sy_d  = '0;
          row_d = row_q + VW'(1);
        end else begin
          sy_d = sy_q + SYW'(1);
        end
      end
    end else begin
      hcnt_d = hcnt_q + HW'(1);
      if (sx_q == SXW'(DOT_W - 1)) begin
        sx_d  = '0;
        col_d = col_q + HW'(1);
      end else begin
        sx_d = sx_q + SXW'(1);
      end
    end
  end

  // Stage 1: flags and read address; stage 2 just delays the flags
  always_comb begin
    logic          draw, hs, vs, in_grid, in_dot;
    logic [AW-1:0] dot_addr;
    draw     = (hcnt_q < HW'(H_DRAW)) && (vcnt_q < VW'(V_DRAW));
    hs       = (hcnt_q >= HW'(HS_START)) && (hcnt_q < HW'(HS_END));
    vs       = (vcnt_q >= VW'(VS_START)) && (vcnt_q < VW'(VS_END));
    in_grid  = (col_q < HW'(COLS)) && (row_q < VW'(ROWS));
    in_dot   = (sx_q >= SXW'(BORDER)) && (sx_q < SXW'(DOT_W - BORDER)) &&
               (sy_q >= SYW'(BORDER)) && (sy_q < SYW'(DOT_H - BORDER));
    // Address only formed inside the grid so the product never overflows
    dot_addr = '0;
    if (in_grid) dot_addr = AW'(row_q) * AW'(COLS) + AW'(col_q);
    s1_raddr_d = front_q ? (MW'(dot_addr) + MW'(NPIX)) : MW'(dot_addr);
    s1_flags_d = {draw, hs, vs, draw && in_grid && in_dot, tint};
    s2_flags_d = s1_flags_q;
  end

  // Stage 3: level -> channel value with saturation
  always_comb begin
    logic [CW-1:0] lin;
    logic [7:0]    chan;
    lin         = CW'(BASE) + CW'(rd_level_q) * CW'(STEP);
    chan        = (lin > CW'(255)) ? 8'hFF : lin[7:0];
    draw_area_d = s2_flags_q[6];
    hsync_d     = s2_flags_q[5];
    vsync_d     = s2_flags_q[4];
    red_d       = (s2_flags_q[3] && s2_flags_q[2]) ? chan : 8'h00;
    green_d     = (s2_flags_q[3] && s2_flags_q[1]) ? chan : 8'h00;
    blue_d      = (s2_flags_q[3] && s2_flags_q[0]) ? chan : 8'h00;
  end

  // Write stream into the back bank and bank swap at the start of vsync
  always_comb begin
    logic [AW-1:0] beat_addr;
    logic          swap;
    wr_addr_d   = wr_addr_q;
    swap_pend_d = swap_pend_q;
    front_d     = front_q;
    wr_fire     = wr.wr_valid && wr_ready_q;
    beat_addr   = wr.wr_sof ? '0 : wr_addr_q;
    wr_maddr    = front_q ? MW'(beat_addr) : (MW'(beat_addr) + MW'(NPIX));
    swap        = swap_pend_q && (hcnt_q == '0) && (vcnt_q == VW'(VS_START));
    if (wr_fire) begin
      if (beat_addr == AW'(NPIX - 1)) begin
        wr_addr_d   = '0;
        swap_pend_d = 1'b1;
      end else begin
        wr_addr_d = beat_addr + AW'(1);
      end
    end
    // A swap only happens while ready is low, so it never meets a write
    if (swap) begin
      front_d     = !front_q;
      swap_pend_d = 1'b0;
    end
    wr_ready_d   = !swap_pend_d;
    frame_done_d = swap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      s1_flags_q  <= '0;
      s2_flags_q  <= '0;
      s1_raddr_q  <= '0;
      wr_addr_q   <= '0;
      swap_pend_q <= 1'b0;
      front_q     <= 1'b0;
      wr_ready_q  <= 1'b0;
      frame_done  <= 1'b0;
      DrawArea    <= 1'b0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s1_flags_q  <= s1_flags_d;
      s2_flags_q  <= s2_flags_d;
      s1_raddr_q  <= s1_raddr_d;
      wr_addr_q   <= wr_addr_d;
      swap_pend_q <= swap_pend_d;
      front_q     <= front_d;
      wr_ready_q  <= wr_ready_d;
      frame_done  <= frame_done_d;
      DrawArea    <= draw_area_d;
      hSync       <= hsync_d;
      vSync       <= vsync_d;
      red         <= red_d;
      green       <= green_d;
      blue        <= blue_d;
    end
  end

  // Frame store: contents survive reset; read data is masked by stage flags
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_maddr] <= wr.wr_data;
    rd_level_q <= mem[s1_raddr_q];
  end

  assign wr.wr_ready = wr_ready_q;

endmodule

// File: tb/tb_dmd_video_gen.sv
// Scoreboard bench for dmd_video_gen on a reduced raster.
module tb_dmd_video_gen;

  localparam int unsigned H_DRAW = 40, H_PORCH = 4, H_SYNC = 6, H_FRAME = 56;
  localparam int unsigned V_DRAW = 20, V_PORCH = 1, V_SYNC = 3, V_FRAME = 26;
  localparam int unsigned DOT_W = 4, DOT_H = 4, BORDER = 1;
  localparam int unsigned COLS = 8, ROWS = 4, BPP = 4;
  localparam int unsigned BASE = 50, STEP = 20;
  localparam int NPIX  = COLS * ROWS;
  localparam int FRAME = H_FRAME * V_FRAME;
  localparam int LAT   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] tint;
  logic       frame_done, DrawArea, hSync, vSync;
  logic [7:0] red, green, blue;

  dmd_wr_if #(.BPP(BPP)) wif ();

  dmd_video_gen #(
    .H_DRAW(H_DRAW), .H_PORCH(H_PORCH), .H_SYNC(H_SYNC), .H_FRAME(H_FRAME),
    .V_DRAW(V_DRAW), .V_PORCH(V_PORCH), .V_SYNC(V_SYNC), .V_FRAME(V_FRAME),
    .DOT_W(DOT_W), .DOT_H(DOT_H), .BORDER(BORDER), .COLS(COLS), .ROWS(ROWS),
    .BPP(BPP), .BASE(BASE), .STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wif.slave), .tint(tint),
    .frame_done(frame_done), .DrawArea(DrawArea), .hSync(hSync), .vSync(vSync),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit chk_col;
    bit da, hs, vs;
    int r, g, b;
  } exp_t;

  exp_t q[$];
  int   mx, my, waddr;
  bit   pend, known, ready_e, done_e;
  int   load_a[NPIX];
  int   disp_a[NPIX];

  function automatic int chan(input int lvl);
    int v;
    v = BASE + lvl * STEP;
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   ins, swap;
    int   sx, sy, col, row, lvl, a;
    if (!rst_n) begin
      mx = 0; my = 0; waddr = 0;
      pend = 0; known = 0; ready_e = 0; done_e = 0;
      q.delete();
    end else begin
      sx  = mx % DOT_W;  col = mx / DOT_W;
      sy  = my % DOT_H;  row = my / DOT_H;
      e.da = (mx < H_DRAW) && (my < V_DRAW);
      e.hs = (mx >= H_DRAW + H_PORCH) && (mx < H_DRAW + H_PORCH + H_SYNC);
      e.vs = (my >= V_DRAW + V_PORCH) && (my < V_DRAW + V_PORCH + V_SYNC);
      ins  = e.da && sx >= BORDER && sx < DOT_W - BORDER &&
             sy >= BORDER && sy < DOT_H - BORDER && col < COLS && row < ROWS;
      lvl  = ins ? disp_a[row * COLS + col] : 0;
      e.chk_col = !ins || known;
      e.r = (ins && tint[2]) ? chan(lvl) : 0;
      e.g = (ins && tint[1]) ? chan(lvl) : 0;
      e.b = (ins && tint[0]) ? chan(lvl) : 0;
      q.push_back(e);

      swap = pend && mx == 0 && my == V_DRAW + V_PORCH;
      if (wif.wr_valid && ready_e) begin
        a = wif.wr_sof ? 0 : waddr;
        load_a[a] = int'(wif.wr_data);
        if (a == NPIX - 1) begin waddr = 0; pend = 1; end
        else waddr = a + 1;
      end
      if (swap) begin
        disp_a = load_a;
        known  = 1;
        pend   = 0;
      end
      done_e  = swap;
      ready_e = !pend;

      mx++;
      if (mx == H_FRAME) begin
        mx = 0;
        my++;
        if (my == V_FRAME) my = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_outputs",
          32'({DrawArea, hSync, vSync, frame_done, wif.wr_ready, red, green, blue}), 0);
    end else begin
      chk("wr_ready", 32'(wif.wr_ready), 32'(ready_e));
      chk("frame_done", 32'(frame_done), 32'(done_e));
      if (q.size() >= LAT) begin
        e = q.pop_front();
        chk("draw_hs_vs", 32'({DrawArea, hSync, vSync}), 32'({e.da, e.hs, e.vs}));
        if (e.chk_col) begin
          chk("red", 32'(red), e.r);
          chk("green", 32'(green), e.g);
          chk("blue", 32'(blue), e.b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Sends n beats; constant level when fixed, else random. gap_pct = idle chance.
  task automatic load(input int n, input bit sof_first, input bit fixed,
                      input int lvl, input int gap_pct);
    int sent = 0;
    int budget = 0;
    while (sent < n && budget < 4 * FRAME) begin
      @(negedge clk);
      budget++;
      if ($urandom_range(99) < gap_pct) begin
        wif.wr_valid = 1'b0;
        wif.wr_sof   = 1'b0;
      end else begin
        wif.wr_valid = 1'b1;
        wif.wr_data  = fixed ? BPP'(lvl) : BPP'($urandom_range((1 << BPP) - 1));
        wif.wr_sof   = sof_first && sent == 0;
        if (wif.wr_ready) sent++;
      end
    end
    @(negedge clk);
    wif.wr_valid = 1'b0;
    wif.wr_sof   = 1'b0;
    if (sent < n) chk("load_budget", sent, n);
  endtask

  // Waits for ready to return; optionally offers junk beats that must be ignored.
  task automatic wait_swap(input bit junk);
    int got = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (wif.wr_ready) begin
        wif.wr_valid = 1'b0;
        got = 1;
        break;
      end
      wif.wr_valid = junk;
      wif.wr_data  = BPP'($urandom_range((1 << BPP) - 1));
    end
    wif.wr_valid = 1'b0;
    chk("swap_wait", got, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    tint  = 3'b111;
    wif.wr_valid = 1'b0;
    wif.wr_sof   = 1'b0;
    wif.wr_data  = '0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle raster: timing only
    run(2 * FRAME);

    // Level 15 saturates, level 10 sits just below saturation
    load(NPIX, 1'b0, 1'b1, 15, 0);
    wait_swap(1'b1);
    run(FRAME + 10);
    load(NPIX, 1'b0, 1'b1, 10, 20);
    wait_swap(1'b0);
    run(FRAME);

    // Random frames and tints
    for (int i = 0; i < 4; i++) begin
      tint = 3'($urandom_range(7));
      load(NPIX, 1'b0, 1'b0, 0, 30);
      wait_swap(i[0]);
      run(FRAME);
    end

    // Restart with sof mid-frame: one swap only
    tint = 3'b111;
    load(NPIX / 2, 1'b0, 1'b0, 0, 10);
    load(NPIX, 1'b1, 1'b0, 0, 10);
    wait_swap(1'b1);
    run(FRAME);

    // Single tint channel on a random frame
    tint = 3'b100;
    load(NPIX, 1'b0, 1'b0, 0, 0);
    wait_swap(1'b0);
    run(FRAME);

    // Reset in the middle of a load and a line
    tint = 3'b111;
    load(NPIX / 2, 1'b0, 1'b0, 0, 0);
    run($urandom_range(1, H_FRAME));
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run(FRAME);
    load(NPIX, 1'b0, 1'b0, 0, 10);
    wait_swap(1'b1);
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
